global_reg_file_mp: RTL and testbench
=====================================

GLOBAL_REG_FILE_MP -- requirements
Module: global_reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each register.
REQ-002 SHALL have parameter NUM_REGS, default 16: register count, range 2..256.
REQ-003 SHALL have parameter NUM_READ_PORTS, default 4: number of independent read ports.
REQ-004 SHALL derive the localparam ADDR_W = clog2(NUM_REGS).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port imm_write_en, input, 1: immediate write strobe from the controller.
REQ-008 SHALL have port imm_write_addr, input, ADDR_W: immediate write target.
REQ-009 SHALL have port imm_write_data, input, DATA_WIDTH: immediate value from the instruction.
REQ-010 SHALL have port ld_issue_en, input, 1: a load targeting ld_issue_addr is issued.
REQ-011 SHALL have port ld_issue_addr, input, ADDR_W: load destination register.
REQ-012 SHALL have port ld_issue_ready, output, 1: the issue is acceptable this cycle.
REQ-013 SHALL have port ld_ret_valid, input, 1: load return data is valid.
REQ-014 SHALL have port ld_ret_ready, output, 1: this block accepts the load return.
REQ-015 SHALL have ports ld_ret_addr, input, ADDR_W, and ld_ret_data, input, DATA_WIDTH: the load return target and value.
REQ-016 SHALL have port rd_addr, input, NUM_READ_PORTS*ADDR_W: flattened read addresses, port p at bits [p*ADDR_W +: ADDR_W].
REQ-017 SHALL have port rd_data, output, NUM_READ_PORTS*DATA_WIDTH: flattened read data.
REQ-018 SHALL have port rd_pending, output, NUM_READ_PORTS: the addressed register awaits a load.
REQ-019 SHALL have port pending_mask, output, NUM_REGS: scoreboard, bit r = register r pending.
REQ-020 SHALL have port err_waw, output, 1: sticky flag, immediate write to a pending register.
REQ-021 SHALL have port err_spurious, output, 1: sticky flag, load return accepted to a non-pending register.

Function
REQ-022 Reads SHALL be combinational per port and SHALL be write-first: an immediate write or an accepted return to the same address in the same cycle appears on rd_data.
REQ-023 rd_pending[p] SHALL be pending[rd_addr[p]] from registered state, with no bypass.
REQ-024 Any address >= NUM_REGS SHALL be ignored on write, SHALL return 0 on read, and SHALL give rd_pending 0.
REQ-025 ld_issue_ready SHALL equal ~pending[ld_issue_addr] AND address in range.
REQ-026 ld_issue_en with ld_issue_ready SHALL set pending[ld_issue_addr] at the next edge; ld_issue_en without ld_issue_ready SHALL change no state.
REQ-027 ld_ret_ready SHALL be 0 only when imm_write_en=1 and imm_write_addr==ld_ret_addr; the immediate write has priority and the return holds.
REQ-028 A return is accepted when ld_ret_valid and ld_ret_ready are both 1; acceptance SHALL write ld_ret_data and clear pending[ld_ret_addr] at the edge.
REQ-029 An issue and an accepted return to the same address in the same cycle SHALL leave pending=1 (issue wins) and SHALL write the data.
REQ-030 An immediate write to a pending register SHALL still write the data, SHALL leave pending unchanged, and SHALL set err_waw.
REQ-031 An accepted return to a non-pending register SHALL write the data and SHALL set err_spurious.
REQ-032 An immediate write and an accepted return to different addresses SHALL both commit in the same cycle.
REQ-033 Write latency SHALL be 1 cycle (visible from the registered array after the edge); read latency SHALL be 0.

Reset
REQ-034 While reset=0, all registers, pending_mask, err_waw and err_spurious SHALL be 0 immediately, independent of clk.
REQ-035 Reset during an outstanding load SHALL clear pending; a later return SHALL count as spurious.
REQ-036 Out of reset, ld_issue_ready SHALL be 1 for in-range addresses and ld_ret_ready SHALL be 1.

Verification
REQ-037 Immediate write r3=0x1234 -> same cycle rd_data(port0, addr 3)=0x1234 via bypass; next cycle all 4 ports reading r3 return 0x1234.
REQ-038 Issue load to r5 -> pending_mask=0x0020 and ld_issue_ready=0 for r5; return r5=0xBEEF -> pending cleared, r5=0xBEEF, no error flags.
REQ-039 Immediate write r7 and return r7 in the same cycle -> ld_ret_ready=0 and r7=imm value; return accepted the next cycle -> r7=return value.
REQ-040 Issue and return to r2 in the same cycle while r2 is pending -> pending[2] stays 1 and r2 takes the returned data.
REQ-041 Immediate write to pending r4 -> err_waw=1 and stays 1; return to non-pending r9 -> err_spurious=1.
REQ-042 Assert reset mid-load with no clk edge -> all outputs 0 at once; later return to r5 -> err_spurious=1.

Source files
------------

// File: rtl/global_reg_file_mp.sv
//==============================================================================
// Module      : global_reg_file_mp
// Description : Multi-read-port register file with a load scoreboard.
//               Immediate writes and load returns commit on the rising
//               edge; reads are combinational and write-first. A pending
//               bit per register tracks outstanding loads, and two sticky
//               flags record write-after-write and spurious-return events.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module global_reg_file_mp #(
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_REGS       = 16,
   parameter int NUM_READ_PORTS = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               imm_write_en,
   input  logic [$clog2(NUM_REGS)-1:0]        imm_write_addr,
   input  logic [DATA_WIDTH-1:0]              imm_write_data,
   input  logic                               ld_issue_en,
   input  logic [$clog2(NUM_REGS)-1:0]        ld_issue_addr,
   output logic                               ld_issue_ready,
   input  logic                               ld_ret_valid,
   output logic                               ld_ret_ready,
   input  logic [$clog2(NUM_REGS)-1:0]        ld_ret_addr,
   input  logic [DATA_WIDTH-1:0]              ld_ret_data,
   input  logic [NUM_READ_PORTS*$clog2(NUM_REGS)-1:0] rd_addr,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]       rd_data,
   output logic [NUM_READ_PORTS-1:0]          rd_pending,
   output logic [NUM_REGS-1:0]                pending_mask,
   output logic                               err_waw,
   output logic                               err_spurious
);

   localparam int ADDR_W = $clog2(NUM_REGS);
   // One extra bit so the range compare never degenerates to a constant.
   localparam logic [ADDR_W:0] c_regs_lim = (ADDR_W+1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_pending;
   logic [NUM_REGS-1:0]   w_pending_nxt;
   logic                  r_err_waw;
   logic                  r_err_spurious;

   logic w_imm_we;
   logic w_ret_acc;
   logic w_ret_we;
   logic w_issue_acc;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < c_regs_lim);
   endfunction

   // The immediate write owns the port when both target the same register.
   assign ld_ret_ready   = ~(imm_write_en && (imm_write_addr == ld_ret_addr));
   assign ld_issue_ready = in_range(ld_issue_addr) & ~r_pending[ld_issue_addr];

   assign w_imm_we  = imm_write_en & in_range(imm_write_addr);
   assign w_ret_acc = ld_ret_valid & ld_ret_ready;
   assign w_ret_we  = w_ret_acc & in_range(ld_ret_addr);

   // A return to the same register recycles its slot this cycle, so a
   // simultaneous issue to that register is honoured and keeps it pending.
   assign w_issue_acc = ld_issue_en &
                        (ld_issue_ready | (w_ret_we && (ld_ret_addr == ld_issue_addr)));

   assign pending_mask = r_pending;
   assign err_waw      = r_err_waw;
   assign err_spurious = r_err_spurious;

   // Scoreboard update: return clears, accepted issue sets (issue wins).
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_ret_we)
         w_pending_nxt[ld_ret_addr] = 1'b0;
      if (w_issue_acc)
         w_pending_nxt[ld_issue_addr] = 1'b1;
   end

   // Register array: immediate write and load return may commit together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REGS; r++)
            r_regs[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_imm_we && (imm_write_addr == ADDR_W'(r)))
               r_regs[r] <= imm_write_data;
            else if (w_ret_we && (ld_ret_addr == ADDR_W'(r)))
               r_regs[r] <= ld_ret_data;
         end
      end
   end

   // Pending bits and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending      <= '0;
         r_err_waw      <= 1'b0;
         r_err_spurious <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_imm_we && r_pending[imm_write_addr])
            r_err_waw <= 1'b1;
         if (w_ret_we && !r_pending[ld_ret_addr])
            r_err_spurious <= 1'b1;
      end
   end

   generate
      for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
         logic [ADDR_W-1:0]     w_addr;
         logic [DATA_WIDTH-1:0] w_data;
         assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

         // Write-first read: same-cycle writes bypass the registered array.
         always_comb begin
            w_data = '0;
            if (in_range(w_addr)) begin
               if (w_imm_we && (imm_write_addr == w_addr))
                  w_data = imm_write_data;
               else if (w_ret_we && (ld_ret_addr == w_addr))
                  w_data = ld_ret_data;
               else
                  w_data = r_regs[w_addr];
            end
         end

         assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
         assign rd_pending[p] = in_range(w_addr) ? r_pending[w_addr] : 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_global_reg_file_mp.sv
//==============================================================================
// Module      : tb_global_reg_file_mp
// Description : Directed self-checking bench for global_reg_file_mp.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_global_reg_file_mp;

   logic        clk;
   logic        reset;
   logic        imm_write_en;
   logic [3:0]  imm_write_addr;
   logic [15:0] imm_write_data;
   logic        ld_issue_en;
   logic [3:0]  ld_issue_addr;
   logic        ld_issue_ready;
   logic        ld_ret_valid;
   logic        ld_ret_ready;
   logic [3:0]  ld_ret_addr;
   logic [15:0] ld_ret_data;
   logic [15:0] rd_addr;
   logic [63:0] rd_data;
   logic [3:0]  rd_pending;
   logic [15:0] pending_mask;
   logic        err_waw;
   logic        err_spurious;

   int n_checks = 0;
   int n_fail   = 0;

   global_reg_file_mp dut (
      .clk            (clk),
      .reset          (reset),
      .imm_write_en   (imm_write_en),
      .imm_write_addr (imm_write_addr),
      .imm_write_data (imm_write_data),
      .ld_issue_en    (ld_issue_en),
      .ld_issue_addr  (ld_issue_addr),
      .ld_issue_ready (ld_issue_ready),
      .ld_ret_valid   (ld_ret_valid),
      .ld_ret_ready   (ld_ret_ready),
      .ld_ret_addr    (ld_ret_addr),
      .ld_ret_data    (ld_ret_data),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_pending     (rd_pending),
      .pending_mask   (pending_mask),
      .err_waw        (err_waw),
      .err_spurious   (err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and sample 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b0;
      imm_write_en   = 1'b0;
      imm_write_addr = '0;
      imm_write_data = '0;
      ld_issue_en    = 1'b0;
      ld_issue_addr  = '0;
      ld_ret_valid   = 1'b0;
      ld_ret_addr    = '0;
      ld_ret_data    = '0;
      rd_addr        = '0;

      // Reset state
      #3;
      check("rst_pending", pending_mask, 64'h0);
      check("rst_errs", {err_waw, err_spurious}, 64'h0);
      check("rst_rd_data", rd_data, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_ret_ready", ld_ret_ready, 64'h1);
      check("rst_issue_ready", ld_issue_ready, 64'h1);

      // Immediate write r3 with same-cycle bypass, then all ports read r3
      imm_write_en = 1'b1; imm_write_addr = 4'd3; imm_write_data = 16'h1234;
      rd_addr = {4'd0, 4'd0, 4'd0, 4'd3};
      #1;
      check("imm_bypass", rd_data, 64'h0000_0000_0000_1234);
      tick();
      imm_write_en = 1'b0;
      rd_addr = {4'd3, 4'd3, 4'd3, 4'd3};
      #1;
      check("imm_all_ports", rd_data, 64'h1234_1234_1234_1234);

      // Load issue to r5, then return 0xBEEF
      ld_issue_en = 1'b1; ld_issue_addr = 4'd5;
      #1;
      check("issue_ready_r5", ld_issue_ready, 64'h1);
      tick();
      ld_issue_en = 1'b0;
      rd_addr = {4'd3, 4'd3, 4'd5, 4'd3};
      #1;
      check("pending_r5", pending_mask, 64'h0020);
      check("issue_busy_r5", ld_issue_ready, 64'h0);
      check("rd_pending_r5", rd_pending, 64'h2);
      ld_ret_valid = 1'b1; ld_ret_addr = 4'd5; ld_ret_data = 16'hBEEF;
      #1;
      check("ret_ready_r5", ld_ret_ready, 64'h1);
      check("ret_bypass_r5", rd_data, 64'h1234_1234_BEEF_1234);
      tick();
      ld_ret_valid = 1'b0;
      #1;
      check("ret_clear_r5", pending_mask, 64'h0);
      check("ret_data_r5", rd_data, 64'h1234_1234_BEEF_1234);
      check("ret_no_err", {err_waw, err_spurious}, 64'h0);

      // Immediate write and return collide on r7
      imm_write_en = 1'b1; imm_write_addr = 4'd7; imm_write_data = 16'h7777;
      ld_ret_valid = 1'b1; ld_ret_addr = 4'd7; ld_ret_data = 16'hAAAA;
      rd_addr = {4'd3, 4'd7, 4'd5, 4'd3};
      #1;
      check("collide_ret_ready", ld_ret_ready, 64'h0);
      check("collide_bypass", rd_data, 64'h1234_7777_BEEF_1234);
      tick();
      imm_write_en = 1'b0;
      ld_ret_valid = 1'b0;
      #1;
      check("collide_imm_wins", rd_data, 64'h1234_7777_BEEF_1234);
      check("collide_no_err", {err_waw, err_spurious}, 64'h0);
      ld_ret_valid = 1'b1;
      #1;
      check("held_ret_ready", ld_ret_ready, 64'h1);
      tick();
      ld_ret_valid = 1'b0;
      #1;
      check("held_ret_data", rd_data, 64'h1234_AAAA_BEEF_1234);
      check("held_ret_spurious", {err_waw, err_spurious}, 64'h1);

      // Issue and return to pending r2 in the same cycle
      ld_issue_en = 1'b1; ld_issue_addr = 4'd2;
      tick();
      #1;
      check("pending_r2", pending_mask, 64'h0004);
      ld_ret_valid = 1'b1; ld_ret_addr = 4'd2; ld_ret_data = 16'h2222;
      #1;
      check("issue_busy_r2", ld_issue_ready, 64'h0);
      tick();
      ld_issue_en = 1'b0;
      ld_ret_valid = 1'b0;
      rd_addr = {4'd2, 4'd7, 4'd5, 4'd3};
      #1;
      check("issue_wins_r2", pending_mask, 64'h0004);
      check("issue_ret_data_r2", rd_data, 64'h2222_AAAA_BEEF_1234);
      check("issue_ret_errs", {err_waw, err_spurious}, 64'h1);

      // Asynchronous reset between edges clears everything
      reset = 1'b0;
      #1;
      check("areset_pending", pending_mask, 64'h0);
      check("areset_rd_data", rd_data, 64'h0);
      check("areset_errs", {err_waw, err_spurious}, 64'h0);
      reset = 1'b1;

      // Immediate write to pending r4, then spurious return to r9
      ld_issue_en = 1'b1; ld_issue_addr = 4'd4;
      tick();
      ld_issue_en = 1'b0;
      imm_write_en = 1'b1; imm_write_addr = 4'd4; imm_write_data = 16'h4444;
      tick();
      imm_write_en = 1'b0;
      rd_addr = {4'd4, 4'd7, 4'd5, 4'd3};
      #1;
      check("waw_flag", {err_waw, err_spurious}, 64'h2);
      check("waw_pending_kept", pending_mask, 64'h0010);
      check("waw_data", rd_data, 64'h4444_0000_0000_0000);
      tick();
      check("waw_sticky", {err_waw, err_spurious}, 64'h2);
      ld_ret_valid = 1'b1; ld_ret_addr = 4'd9; ld_ret_data = 16'h9999;
      tick();
      ld_ret_valid = 1'b0;
      #1;
      check("spurious_r9", {err_waw, err_spurious}, 64'h3);
      check("spurious_pending", pending_mask, 64'h0010);

      // Reset mid-load with no clock edge, then a late return is spurious
      ld_issue_en = 1'b1; ld_issue_addr = 4'd5;
      tick();
      ld_issue_en = 1'b0;
      #1;
      check("midload_pending", pending_mask, 64'h0030);
      reset = 1'b0;
      #2;
      check("midload_rst_pending", pending_mask, 64'h0);
      check("midload_rst_errs", {err_waw, err_spurious}, 64'h0);
      check("midload_rst_data", rd_data, 64'h0);
      check("midload_rst_ready", ld_issue_ready, 64'h1);
      reset = 1'b1;
      ld_ret_valid = 1'b1; ld_ret_addr = 4'd5; ld_ret_data = 16'h5555;
      rd_addr = {4'd5, 4'd0, 4'd0, 4'd0};
      tick();
      ld_ret_valid = 1'b0;
      #1;
      check("late_ret_spurious", {err_waw, err_spurious}, 64'h1);
      check("late_ret_data", rd_data, 64'h5555_0000_0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
